native2stream: RTL and testbench

- Converts a native first-word-fall-through-free (standard mode, 1-cycle read latency) FIFO read port into an AXI4-Stream master.
- FIFO word layout is {tlast, tdata}, MSB = tlast. This is the format the write side produces.
- Sits on the read side of the sample FIFO and feeds downstream AXIS consumers such as DMA and packetizers.
- Sustains one beat per clock under continuous tready, using a small internal output buffer.

---
 rtl/native2stream_pkg.sv | 11 +
 rtl/native2stream_if.sv | 31 +++
 rtl/native2stream_buf.sv | 46 ++++
 rtl/native2stream.sv | 66 ++++++
 tb/tb_native2stream.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/native2stream_pkg.sv
// Shared types and helpers for the native-FIFO to AXI4-Stream bridge.
// Imported by the interface, the output buffer and the top level.
package native2stream_pkg;

   typedef logic [1:0] occ_t;

   function automatic int keep_w(input int w);
      return w / 8;
   endfunction

endpackage

// File: rtl/native2stream_if.sv
// AXI4-Stream bundle driven by native2stream.
// Master drives the beat, slave returns tready.
interface native2stream_if
   import native2stream_pkg::*;
#(
   parameter int WIDTH = 16
);

   logic                       tvalid;
   logic                       tready;
   logic [WIDTH-1:0]           tdata;
   logic [keep_w(WIDTH)-1:0]   tkeep;
   logic                       tlast;

   modport master (
      output tvalid,
      input  tready,
      output tdata,
      output tkeep,
      output tlast
   );

   modport slave (
      input  tvalid,
      output tready,
      input  tdata,
      input  tkeep,
      input  tlast
   );

endinterface

// File: rtl/native2stream_buf.sv
// Two-entry synchronous FIFO holding {last, data} words.
// Write and read may occur in the same cycle.
module native2stream_buf
   import native2stream_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr,
   input  logic [WIDTH:0] wdata,
   input  logic           rd,
   output logic [WIDTH:0] rdata,
   output occ_t           occ
);

   logic [WIDTH:0] mem [2];
   logic           head;
   logic           tail;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (wr) begin
            mem[tail] <= wdata;
            tail      <= ~tail;
         end
         if (rd) begin
            head <= ~head;
         end
         unique case ({wr, rd})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign rdata = mem[head];

endmodule

// File: rtl/native2stream.sv
// Native (1-cycle latency) FIFO read port to AXI4-Stream master bridge.
// Reads are issued only when buffer space is guaranteed for in-flight data.
module native2stream
   import native2stream_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   output logic                 fifo_rd,
   input  logic [WIDTH:0]       fifo_data,
   native2stream_if.master      m_axis,
   output logic [CNT_WIDTH-1:0] pkt_cnt
);

   localparam int KEEP_W = keep_w(WIDTH);

   logic           infl;
   logic           pop;
   occ_t           occ;
   logic [2:0]     lvl;
   logic [WIDTH:0] head;

   assign pop = m_axis.tvalid & m_axis.tready;

   // Committed slots after this cycle's pop; a new read needs one free.
   assign lvl = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

   assign fifo_rd = ~rst & ~fifo_empty & (lvl < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         infl <= 1'b0;
      end else begin
         infl <= fifo_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt <= '0;
      end else if (pop & m_axis.tlast) begin
         pkt_cnt <= pkt_cnt + 1'b1;
      end
   end

   native2stream_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .wr    (infl),
      .wdata (fifo_data),
      .rd    (pop),
      .rdata (head),
      .occ   (occ)
   );

   assign m_axis.tvalid = (occ != 2'd0);
   assign m_axis.tdata  = head[WIDTH-1:0];
   assign m_axis.tlast  = head[WIDTH];
   assign m_axis.tkeep  = {KEEP_W{1'b1}};

endmodule

// File: tb/tb_native2stream.sv
// Scoreboard bench for native2stream with a behavioural native FIFO.
// Stimulus queues expected beats; the negedge monitor checks them.
module tb_native2stream;

   localparam int W    = 16;
   localparam int CW   = 32;
   localparam int CK_NONE    = 0;
   localparam int CK_RESET   = 1;
   localparam int CK_CNT     = 2;
   localparam int CK_TIMEOUT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [W:0]    fifo_data = '0;
   logic [CW-1:0] pkt_cnt;

   native2stream_if #(.WIDTH(W)) m_axis ();

   native2stream #(
      .WIDTH     (W),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .m_axis     (m_axis),
      .pkt_cnt    (pkt_cnt)
   );

   always #5 clk = ~clk;

   // behavioural native FIFO, standard read mode
   logic [W:0] mem [512];
   int         pushed = 0;
   int         popped = 0;
   logic       force_empty = 1'b0;

   assign fifo_empty = force_empty || (pushed == popped);

   always @(posedge clk) begin
      if (rst) begin
         popped    <= pushed;
         fifo_data <= '0;
      end else if (fifo_rd) begin
         fifo_data <= mem[popped];
         popped    <= popped + 1;
      end
   end

   logic [W:0] exp_q [$];
   int         chk = CK_NONE;
   logic [CW-1:0] exp_pkt = '0;
   bit         mode_nogap  = 1'b0;
   bit         mode_single = 1'b0;
   bit         mode_gap    = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   function automatic void cmp(input string nm,
                               input logic [31:0] got,
                               input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endfunction

   // monitor / scoreboard
   int         cyc = 0;
   bit         prev_stall = 1'b0;
   logic [W:0] prev_beat = '0;
   int         hs_win = 0;
   int         last_hs = 0;
   int         rd_n = 0;
   int         rd_cyc = 0;
   bit         seen = 1'b0;
   bit         saw_drop = 1'b0;
   bit         prev_gap = 1'b0;
   logic [W:0] beat;
   logic [W:0] want;

   always @(negedge clk) begin
      cyc++;
      beat = {m_axis.tlast, m_axis.tdata};
      cmp("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
      cmp("occ_plus_infl_le2",
          32'((32'(dut.occ) + 32'(dut.infl)) <= 32'd2), 32'd1);
      if (!rst && prev_stall) begin
         cmp("stall_valid", 32'(m_axis.tvalid), 32'd1);
         cmp("stall_beat", 32'(beat), 32'(prev_beat));
      end
      if (mode_single) begin
         if (fifo_rd) begin
            rd_n++;
            rd_cyc = cyc;
         end
         if (m_axis.tvalid && !seen) begin
            seen = 1'b1;
            cmp("single_latency", 32'(cyc - rd_cyc), 32'd2);
            cmp("single_rd_count", 32'(rd_n), 32'd1);
         end
      end else begin
         rd_n = 0;
         seen = 1'b0;
      end
      if (!rst && m_axis.tvalid && m_axis.tready) begin
         if (exp_q.size() == 0) begin
            cmp("unexpected_beat", 32'(beat), 32'h1ffff);
         end else begin
            want = exp_q.pop_front();
            cmp("beat", 32'(beat), 32'(want));
         end
         if (mode_nogap) begin
            if (hs_win > 0) cmp("nogap", 32'(cyc - last_hs), 32'd1);
            hs_win++;
            last_hs = cyc;
         end
      end
      if (!mode_nogap) hs_win = 0;
      if (mode_gap) begin
         if (!m_axis.tvalid) saw_drop = 1'b1;
      end else if (prev_gap) begin
         cmp("gap_valid_dropped", 32'(saw_drop), 32'd1);
         saw_drop = 1'b0;
      end
      prev_gap = mode_gap;
      unique case (chk)
         CK_RESET: begin
            cmp("rst_fifo_rd", 32'(fifo_rd), 32'd0);
            cmp("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
            cmp("rst_tdata", 32'(m_axis.tdata), 32'd0);
            cmp("rst_tlast", 32'(m_axis.tlast), 32'd0);
            cmp("rst_pkt_cnt", pkt_cnt, 32'd0);
            cmp("rst_tkeep", 32'(m_axis.tkeep), 32'd3);
            cmp("rst_occ", 32'(dut.occ), 32'd0);
            cmp("rst_infl", 32'(dut.infl), 32'd0);
         end
         CK_CNT:     cmp("pkt_cnt", pkt_cnt, exp_pkt);
         CK_TIMEOUT: cmp("drain_timeout", 32'd1, 32'd0);
         default: ;
      endcase
      prev_stall = !rst && m_axis.tvalid && !m_axis.tready;
      prev_beat  = beat;
   end

   // stimulus
   task automatic push(input logic last, input logic [W-1:0] d,
                       input bit track);
      mem[pushed] = {last, d};
      pushed++;
      if (track) exp_q.push_back({last, d});
   endtask

   task automatic req(input int k);
      chk = k;
      @(negedge clk);
      #1 chk = CK_NONE;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input bit bp);
      logic [15:0] pat;
      bit          done;
      pat  = 16'b1001_1100_1011_0010;
      done = 1'b0;
      for (int k = 0; k < 800 && !done; k++) begin
         @(posedge clk);
         #1;
         if (bp) m_axis.tready = pat[k % 16];
         if (exp_q.size() == 0) done = 1'b1;
      end
      m_axis.tready = 1'b1;
      tick(2);
      if (!done) req(CK_TIMEOUT);
   endtask

   initial begin
      m_axis.tready = 1'b1;
      push(1'b0, 16'h1234, 1'b0);
      tick(1);
      req(CK_RESET);
      tick(1);
      rst = 1'b0;
      tick(2);

      mode_single = 1'b1;
      push(1'b1, 16'hA5A5, 1'b1);
      drain(1'b0);
      mode_single = 1'b0;
      exp_pkt = 32'd1;
      req(CK_CNT);

      mode_nogap = 1'b1;
      for (int i = 0; i < 16; i++) push(i == 15, 16'(i), 1'b1);
      drain(1'b0);
      mode_nogap = 1'b0;
      exp_pkt = 32'd2;
      req(CK_CNT);

      for (int i = 0; i < 64; i++)
         push((i % 16) == 15, 16'h1000 + 16'(i * 3), 1'b1);
      drain(1'b1);
      exp_pkt = 32'd6;
      req(CK_CNT);

      for (int i = 0; i < 8; i++) push(i == 7, 16'hB000 + 16'(i), 1'b1);
      tick(3);
      force_empty = 1'b1;
      mode_gap    = 1'b1;
      tick(3);
      force_empty = 1'b0;
      drain(1'b0);
      mode_gap = 1'b0;
      tick(1);
      exp_pkt = 32'd7;
      req(CK_CNT);

      for (int i = 0; i < 10; i++) push(i == 9, 16'hC000 + 16'(i), 1'b1);
      tick(5);
      rst = 1'b1;
      exp_q.delete();
      tick(1);
      req(CK_RESET);
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) push(i == 3, 16'hD000 + 16'(i), 1'b1);
      drain(1'b0);
      exp_pkt = 32'd1;
      req(CK_CNT);

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
